piano_voice_allocator: RTL and testbench
========================================

Name: piano_voice_allocator

Overview:
- Shares a small pool of tone-generator voices among the eight conditioned piano keys (C, D, E, F, G, A, B, C2).
- Sits between the input conditioners and the tone generators.
- Turns key-press and key-release edges into per-voice enable, period and retrigger controls.
- When every voice is busy, a new key press takes the least recently allocated voice.

Parameters:
- NUM_KEYS, 8, number of key inputs; bit 0 = C … bit 7 = C2.
- NUM_VOICES, 4, number of tone-generator voices in the pool; 2..8.
- DIV_W, 17, width of the per-voice period word.

Ports:
- clk  in  1  system clock (25 MHz).
- reset_n  in  1  asynchronous active-low reset.
- key  in  NUM_KEYS  debounced key levels; 1 = pressed.
- voice_en  out  NUM_VOICES  voice v is sounding.
- voice_key  out  NUM_VOICES*3  key index owned by voice v; slice [3v+2:3v].
- voice_div  out  NUM_VOICES*DIV_W  period in clocks for voice v; slice [DIV_W*v+DIV_W-1:DIV_W*v].
- voice_retrig  out  NUM_VOICES  one-cycle pulse; voice v must restart its phase counter.
- steal  out  1  one-cycle pulse; the current allocation evicted a busy voice.
- active_cnt  out  4  number of voices with voice_en = 1.

Behaviour:
- Reset (asynchronous, reset_n = 0) forces:
  - voice_en = 0, voice_key = 0, voice_div = 0, voice_retrig = 0, steal = 0, active_cnt = 0;
  - key_prev = 0, pending_on = 0, pending_off = 0;
  - rank[v] = NUM_VOICES-1-v, so voice 0 is oldest.
- Reset may assert at any time; all in-flight pending events are discarded.
- Keys held when reset releases are seen as new presses.
- Edge detection:
  - key_prev is registered every cycle.
  - rise = key & ~key_prev; fall = ~key & key_prev.
- Pending registers, updated every cycle:
  - rise sets pending_on[k].
  - fall clears pending_on[k]; it sets pending_off[k] only if some voice owns k with voice_en = 1.
  - The bit being serviced this cycle is cleared unless the same key sets it again in the same cycle.
- Service: one event per cycle, priority order:
  - (1) Lowest-index set pending_off bit k: the voice owning k gets voice_en = 0. voice_key and voice_div hold. Ranks are unchanged.
  - (2) Otherwise, lowest-index set pending_on bit k:
    - If k already owns an enabled voice: no-op, bit cleared.
    - Else if a voice is free: take the lowest-index free voice.
    - Else: take the voice with rank NUM_VOICES-1 and pulse steal.
    - The chosen voice v gets voice_en = 1, voice_key = k, voice_div = PERIOD[k], and voice_retrig[v] pulses.
    - Rank update: every u with rank[u] < rank[v] increments; rank[v] = 0.
- Latency:
  - Key change present before edge N → pending bit set at edge N → outputs updated at edge N+1, if no higher-priority event is queued.
  - Each additional queued event adds 1 cycle.
- PERIOD table (clocks at 25 MHz), zero-extended or truncated to DIV_W:
  - C 95566, D 85121, E 75850, F 71592, G 63776, A 56818, B 50618, C2 47774.
- Rank permutation:
  - Ranks always form a permutation of 0..NUM_VOICES-1.
  - Rank width is ceil(log2(NUM_VOICES)).
- Same-key press/release:
  - Release then re-press of the same key before its off is serviced: off is serviced first, then on.
  - The key gets a voice again, by the same free/steal rule, with a retrig pulse.
- Press and release of a key before its on is serviced: no voice is ever allocated.
- Outputs:
  - active_cnt is the registered popcount of voice_en, updated the same edge as voice_en.
  - voice_retrig and steal are registered and high for exactly one cycle.

Test Plan:
- Reset, then key = 8'h01 at cycle 0 → at edge 2: voice_en = 4'b0001, voice_key[2:0] = 0, voice_div[16:0] = 95566, voice_retrig = 4'b0001 for one cycle, active_cnt = 1.
- key 8'h00 → 8'h0F in one cycle → voices 0..3 get keys 0,1,2,3 on four consecutive cycles; active_cnt reaches 4; steal never pulses.
- With keys 0..3 held in allocation order, press key 5 → voice 0 (oldest) gets voice_key = 5, voice_div = 56818; steal and voice_retrig[0] pulse; voice_en stays 4'b1111.
- Then press key 6 → voice 1 is stolen (next oldest).
- Release key 2 → voice 2 voice_en = 0 two cycles later; voice_key stays 2; active_cnt = 3.
- Next press of key 7 → voice 2 gets key 7 with no steal.
- Key 4 pulsed high for one cycle while three off events are queued → no allocation for key 4; key 4 never appears in any enabled voice_key.
- reset_n low for 1 cycle while voices are active → all outputs 0 immediately.
- Held keys are re-allocated starting 2 cycles after release, lowest key first.

Source files
------------

// File: rtl/piano_voice_allocator.sv
// piano_voice_allocator
//   Shares a pool of NUM_VOICES tone-generator voices among NUM_KEYS
//   conditioned piano keys. Key edges are queued as pending on/off events
//   and one event is serviced per clock. When no voice is free, a press
//   steals the least recently allocated voice.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   key          debounced key levels, 1 = pressed (bit 0 = C ... bit 7 = C2)
//   voice_en     voice v is sounding
//   voice_key    key index owned by voice v, slice [3v+2:3v]
//   voice_div    period in clocks for voice v, slice [DIV_W*v +: DIV_W]
//   voice_retrig one-cycle pulse, voice v restarts its phase counter
//   steal        one-cycle pulse, this allocation evicted a busy voice
//   active_cnt   number of voices with voice_en = 1
module piano_voice_allocator #(
  parameter int NUM_KEYS   = 8,
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 17
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_KEYS-1:0]         key,
  output logic [NUM_VOICES-1:0]       voice_en,
  output logic [NUM_VOICES*3-1:0]     voice_key,
  output logic [NUM_VOICES*DIV_W-1:0] voice_div,
  output logic [NUM_VOICES-1:0]       voice_retrig,
  output logic                        steal,
  output logic [3:0]                  active_cnt
);

  localparam int VW = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0] key_prev, pend_on, pend_off;
  logic [2:0]          vkey [NUM_VOICES];
  logic [DIV_W-1:0]    vdiv [NUM_VOICES];
  logic [VW-1:0]       rank [NUM_VOICES];

  logic [NUM_KEYS-1:0]   rise, fall, on_clr, off_clr, own_n;
  logic [NUM_KEYS-1:0]   pend_on_n, pend_off_n;
  logic [NUM_VOICES-1:0] en_n, retrig_n;
  logic                  steal_n;
  logic [2:0]            key_n  [NUM_VOICES];
  logic [DIV_W-1:0]      div_n  [NUM_VOICES];
  logic [VW-1:0]         rank_n [NUM_VOICES];
  logic [2:0]            svc_k;
  logic [VW-1:0]         pick;
  logic                  have_free, owned;
  logic [3:0]            cnt_n;

  function automatic logic [DIV_W-1:0] period(input logic [2:0] k);
    int unsigned p;
    case (k)
      3'd0:    p = 95566;
      3'd1:    p = 85121;
      3'd2:    p = 75850;
      3'd3:    p = 71592;
      3'd4:    p = 63776;
      3'd5:    p = 56818;
      3'd6:    p = 50618;
      default: p = 47774;
    endcase
    return DIV_W'(p);
  endfunction

  function automatic logic [2:0] lowest(input logic [NUM_KEYS-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOICES; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  assign rise = key & ~key_prev;
  assign fall = ~key & key_prev;

  always_comb begin
    en_n      = voice_en;
    retrig_n  = '0;
    steal_n   = 1'b0;
    on_clr    = '0;
    off_clr   = '0;
    svc_k     = '0;
    pick      = '0;
    have_free = 1'b0;
    owned     = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_n[v]  = vkey[v];
      div_n[v]  = vdiv[v];
      rank_n[v] = rank[v];
    end

    if (|pend_off) begin
      // Releases first: silence the owner, keep its key/period and age.
      svc_k = lowest(pend_off);
      off_clr[svc_k] = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++)
        if (voice_en[v] && vkey[v] == svc_k) en_n[v] = 1'b0;
    end else if (|pend_on) begin
      svc_k = lowest(pend_on);
      on_clr[svc_k] = 1'b1;
      for (int v = 0; v < NUM_VOICES; v++)
        if (voice_en[v] && vkey[v] == svc_k) owned = 1'b1;
      if (!owned) begin
        for (int v = NUM_VOICES - 1; v >= 0; v--)
          if (!voice_en[v]) begin
            pick      = VW'(v);
            have_free = 1'b1;
          end
        if (!have_free) begin
          // Oldest allocation carries the highest rank.
          for (int v = 0; v < NUM_VOICES; v++)
            if (rank[v] == VW'(NUM_VOICES - 1)) pick = VW'(v);
          steal_n = 1'b1;
        end
        en_n[pick]     = 1'b1;
        key_n[pick]    = svc_k;
        div_n[pick]    = period(svc_k);
        retrig_n[pick] = 1'b1;
        for (int u = 0; u < NUM_VOICES; u++)
          if (rank[u] < rank[pick]) rank_n[u] = rank[u] + 1'b1;
        rank_n[pick] = '0;
      end
    end

    // Ownership after this cycle's update decides whether a release needs
    // an off event; this covers a key being allocated in the same cycle.
    own_n = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      for (int k = 0; k < NUM_KEYS; k++)
        if (en_n[v] && key_n[v] == 3'(k)) own_n[k] = 1'b1;

    pend_on_n  = (pend_on & ~on_clr & ~fall) | rise;
    pend_off_n = (pend_off & ~off_clr) | (fall & own_n);
    cnt_n      = popcount(en_n);
  end

  // State register: edge history, event queue, voice table and ages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev     <= '0;
      pend_on      <= '0;
      pend_off     <= '0;
      voice_en     <= '0;
      voice_retrig <= '0;
      steal        <= 1'b0;
      active_cnt   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= '0;
        vdiv[v] <= '0;
        rank[v] <= VW'(NUM_VOICES - 1 - v);
      end
    end else begin
      key_prev     <= key;
      pend_on      <= pend_on_n;
      pend_off     <= pend_off_n;
      voice_en     <= en_n;
      voice_retrig <= retrig_n;
      steal        <= steal_n;
      active_cnt   <= cnt_n;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= key_n[v];
        vdiv[v] <= div_n[v];
        rank[v] <= rank_n[v];
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_key[3*g +: 3]         = vkey[g];
    assign voice_div[DIV_W*g +: DIV_W] = vdiv[g];
  end

endmodule

// File: tb/tb_piano_voice_allocator.sv
// tb_piano_voice_allocator
//   Directed-vector bench for piano_voice_allocator with hand-computed
//   expectations. Inputs change and outputs are sampled on the falling
//   clock edge; the design acts on the rising edge.
module tb_piano_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  key = '0;
  logic [3:0]  voice_en;
  logic [11:0] voice_key;
  logic [67:0] voice_div;
  logic [3:0]  voice_retrig;
  logic        steal;
  logic [3:0]  active_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piano_voice_allocator #(.NUM_KEYS(8), .NUM_VOICES(4), .DIV_W(17)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key          (key),
    .voice_en     (voice_en),
    .voice_key    (voice_key),
    .voice_div    (voice_div),
    .voice_retrig (voice_retrig),
    .steal        (steal),
    .active_cnt   (active_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nstep(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic k4_seen;

    // Reset state
    nstep(3);
    chk("rst_en", 64'(voice_en), 64'h0);
    chk("rst_key", 64'(voice_key), 64'h0);
    chk("rst_div", 64'(voice_div), 64'h0);
    chk("rst_retrig", 64'(voice_retrig), 64'h0);
    chk("rst_steal", 64'(steal), 64'h0);
    chk("rst_cnt", 64'(active_cnt), 64'h0);
    reset_n = 1'b1;
    nstep(1);

    // Single press of C: two edges of latency
    key = 8'h01;
    nstep(1);
    chk("c_lat_en", 64'(voice_en), 64'h0);
    nstep(1);
    chk("c_en", 64'(voice_en), 64'h1);
    chk("c_key", 64'(voice_key[2:0]), 64'd0);
    chk("c_div", 64'(voice_div[16:0]), 64'd95566);
    chk("c_retrig", 64'(voice_retrig), 64'h1);
    chk("c_cnt", 64'(active_cnt), 64'd1);
    nstep(1);
    chk("c_retrig_off", 64'(voice_retrig), 64'h0);

    // Release everything, then press C..F together
    key = 8'h00;
    nstep(3);
    chk("idle_en", 64'(voice_en), 64'h0);
    key = 8'h0F;
    nstep(2);
    chk("chord_en0", 64'(voice_en), 64'h1);
    chk("chord_steal0", 64'(steal), 64'h0);
    nstep(1);
    chk("chord_en1", 64'(voice_en), 64'h3);
    chk("chord_steal1", 64'(steal), 64'h0);
    nstep(1);
    chk("chord_en2", 64'(voice_en), 64'h7);
    chk("chord_steal2", 64'(steal), 64'h0);
    nstep(1);
    chk("chord_en3", 64'(voice_en), 64'hF);
    chk("chord_steal3", 64'(steal), 64'h0);
    chk("chord_keys", 64'(voice_key), 64'(12'b011_010_001_000));
    chk("chord_cnt", 64'(active_cnt), 64'd4);

    // Press A: voice 0 is oldest and gets stolen
    key = 8'h2F;
    nstep(2);
    chk("a_key0", 64'(voice_key[2:0]), 64'd5);
    chk("a_div0", 64'(voice_div[16:0]), 64'd56818);
    chk("a_steal", 64'(steal), 64'h1);
    chk("a_retrig", 64'(voice_retrig), 64'h1);
    chk("a_en", 64'(voice_en), 64'hF);
    nstep(1);
    chk("a_steal_off", 64'(steal), 64'h0);

    // Press B: voice 1 is next oldest
    key = 8'h6F;
    nstep(2);
    chk("b_key1", 64'(voice_key[5:3]), 64'd6);
    chk("b_div1", 64'(voice_div[33:17]), 64'd50618);
    chk("b_steal", 64'(steal), 64'h1);
    chk("b_retrig", 64'(voice_retrig), 64'h2);

    // Release E: voice 2 goes quiet two cycles later, key kept
    key = 8'h6B;
    nstep(1);
    chk("e_off_lat", 64'(voice_en), 64'hF);
    nstep(1);
    chk("e_off_en", 64'(voice_en), 64'hB);
    chk("e_off_key", 64'(voice_key[8:6]), 64'd2);
    chk("e_off_cnt", 64'(active_cnt), 64'd3);

    // Press C2: free voice 2, no steal
    key = 8'hEB;
    nstep(2);
    chk("c2_key2", 64'(voice_key[8:6]), 64'd7);
    chk("c2_div2", 64'(voice_div[50:34]), 64'd47774);
    chk("c2_steal", 64'(steal), 64'h0);
    chk("c2_retrig", 64'(voice_retrig), 64'h4);
    chk("c2_en", 64'(voice_en), 64'hF);

    // Release F, A, B and pulse G for one cycle behind the three offs
    key = 8'h93;
    nstep(1);
    key = 8'h83;
    k4_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int v = 0; v < 4; v++)
        if (voice_en[v] && voice_key[3*v +: 3] == 3'd4) k4_seen = 1'b1;
      nstep(1);
    end
    chk("g_pulse_none", 64'(k4_seen), 64'h0);
    chk("g_pulse_en", 64'(voice_en), 64'h4);
    chk("g_pulse_cnt", 64'(active_cnt), 64'd1);

    // Asynchronous reset mid-cycle with a voice active
    nstep(1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_en", 64'(voice_en), 64'h0);
    chk("arst_key", 64'(voice_key), 64'h0);
    chk("arst_div", 64'(voice_div), 64'h0);
    chk("arst_cnt", 64'(active_cnt), 64'h0);
    nstep(1);
    reset_n = 1'b1;

    // Held keys C, D, C2 come back as new presses, lowest first
    nstep(2);
    chk("rel_en0", 64'(voice_en), 64'h1);
    chk("rel_key0", 64'(voice_key[2:0]), 64'd0);
    nstep(1);
    chk("rel_en1", 64'(voice_en), 64'h3);
    chk("rel_key1", 64'(voice_key[5:3]), 64'd1);
    nstep(1);
    chk("rel_en2", 64'(voice_en), 64'h7);
    chk("rel_key2", 64'(voice_key[8:6]), 64'd7);
    chk("rel_cnt", 64'(active_cnt), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
